spi_apb_cfg_master: RTL and testbench

// - APB initiator that programs and drains the SPI master register block
//   (STATUS/CLKDIV/SPICMD/SPIADR/SPILEN/SPIDUM/TXFIFO/RXFIFO/INTCFG/INTSTA) on behalf of a local controller.
// - Converts one valid/ready request into one APB3 SETUP+ACCESS transfer and returns the result on a valid/ready response channel.
// - Honours PREADY wait states and reports PSLVERR. A wait-state watchdog aborts a transfer that stalls too long.

---
 rtl/spi_apb_cfg_master.sv | 132 +++++++++++++
 tb/tb_spi_apb_cfg_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_apb_cfg_master
// Description : Valid/ready to APB3 initiator for the SPI master register
//               block, with PREADY wait-state watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_apb_cfg_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_WIDTH   = 9
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_WIDTH-1:0] c_TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic [TO_CNT_WIDTH-1:0]     r_to_cnt;
  logic [APB_ADDR_WIDTH-1:0]   r_paddr;
  logic [31:0]                 r_pwdata;
  logic                        r_pwrite;
  logic [31:0]                 r_rsp_rdata;
  logic                        r_rsp_err;
  logic                        r_rsp_timeout;
  logic                        w_timeout;
  logic                        w_unused_addr;

  // Word-aligned bus: the byte-offset bits never reach PADDR.
  assign w_unused_addr = ^req_addr[1:0];

  assign w_timeout = c_TO_EN && (r_to_cnt == c_TO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (PREADY || w_timeout) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_to_cnt      <= '0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pwrite      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_paddr  <= {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
            r_pwdata <= req_wdata;
            r_pwrite <= req_write;
          end
        end
        S_SETUP: r_to_cnt <= '0;
        S_ACCESS: begin
          // PREADY takes priority over a watchdog expiry on the same cycle.
          if (PREADY) begin
            r_rsp_rdata   <= r_pwrite ? 32'h0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_rdata   <= 32'h0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign PSEL        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE     = (r_state == S_ACCESS);
  assign rsp_valid   = (r_state == S_RESP);
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PWRITE      = r_pwrite;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_apb_cfg_master
// Description : Self-checking bench for spi_apb_cfg_master with an APB slave
//               responder and a transaction-level expected-result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_apb_cfg_master;

  localparam int AW = 12;
  localparam int TO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int checks   = 0;
  int failures = 0;

  spi_apb_cfg_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .TO_CNT_WIDTH  (5)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // Slave inputs outside ACCESS carry junk; the master must ignore them.
  task automatic drive_junk();
    PREADY  = 1'($urandom);
    PRDATA  = $urandom;
    PSLVERR = 1'($urandom);
  endtask

  // One complete transfer. waits = ACCESS cycles with PREADY low before the
  // ready cycle; hold = cycles rsp_ready stays low once the response shows.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [31:0] prd, input int waits, input logic serr, input int hold);
    logic [AW-1:0] exp_addr;
    logic          exp_to;
    logic          exp_err;
    logic [31:0]   exp_rd;
    int            exp_acc;
    int            acc;
    logic [31:0]   rd_s;
    logic          err_s;
    logic          to_s;
    exp_addr = {addr[AW-1:2], 2'b00};
    exp_to   = (waits >= TO);
    exp_acc  = exp_to ? TO : waits + 1;
    exp_err  = exp_to | serr;
    exp_rd   = (exp_to || wr) ? 32'h0 : prd;

    @(negedge HCLK);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd;
    drive_junk();
    @(negedge HCLK);
    req_valid = 1'b0; req_addr = AW'($urandom); req_write = 1'($urandom); req_wdata = $urandom;
    drive_junk();
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== exp_addr || PWRITE !== wr || PWDATA !== wd) begin
      failures++;
      $display("FAIL setup: psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h want 1 0 %h %b %h",
               PSEL, PENABLE, PADDR, PWRITE, PWDATA, exp_addr, wr, wd);
    end

    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) break;
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== exp_addr || PWRITE !== wr || PWDATA !== wd) begin
        failures++;
        $display("FAIL access: psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h want 1 1 %h %b %h",
                 PSEL, PENABLE, PADDR, PWRITE, PWDATA, exp_addr, wr, wd);
        break;
      end
      acc++;
      PREADY  = (acc == waits + 1);
      PRDATA  = PREADY ? prd : $urandom;
      PSLVERR = PREADY ? serr : 1'($urandom);
    end

    checks++;
    if (rsp_valid !== 1'b1 || acc != exp_acc) begin
      failures++;
      $display("FAIL rsp_timing: rsp_valid=%b access_cycles=%0d want 1 %0d", rsp_valid, acc, exp_acc);
    end
    checks++;
    if (rsp_rdata !== exp_rd || rsp_err !== exp_err || rsp_timeout !== exp_to || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      failures++;
      $display("FAIL rsp_data: rdata=%h err=%b to=%b psel=%b pen=%b want %h %b %b 0 0",
               rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, exp_rd, exp_err, exp_to);
    end
    rd_s = rsp_rdata; err_s = rsp_err; to_s = rsp_timeout;

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      drive_junk();
      @(negedge HCLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd_s || rsp_err !== err_s || rsp_timeout !== to_s ||
          req_ready !== 1'b0 || PSEL !== 1'b0) begin
        failures++;
        $display("FAIL rsp_hold: valid=%b rdata=%h err=%b to=%b req_ready=%b psel=%b want 1 %h %b %b 0 0",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, PSEL, rd_s, err_s, to_s);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drive_junk();
    @(negedge HCLK);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PSEL !== 1'b0) begin
      failures++;
      $display("FAIL rsp_release: rsp_valid=%b req_ready=%b psel=%b want 0 1 0", rsp_valid, req_ready, PSEL);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== '0 || PWDATA !== 32'h0 ||
        rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rv=%b rd=%h err=%b to=%b rr=%b want all zero, rr=1",
               tag, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    check_reset_values("reset_state");
    HRESET = 1'b0;
  endtask

  task automatic test_write_basic();
    xfer(12'h004, 1'b1, 32'h0000_0010, $urandom, 0, 1'b0, 0);
  endtask

  task automatic test_read_waits();
    xfer(12'h020, 1'b0, $urandom, 32'hCAFE_F00D, 3, 1'b0, 0);
  endtask

  task automatic test_read_slverr();
    xfer(12'h023, 1'b0, $urandom, 32'h1234_5678, 0, 1'b1, 0);
  endtask

  task automatic test_timeout();
    xfer(12'h018, 1'b0, $urandom, 32'hDEAD_BEEF, 1000, 1'b0, 0);
    xfer(12'h008, 1'b0, $urandom, 32'h0BAD_CAFE, 1, 1'b0, 0);
    xfer(12'h00C, 1'b1, 32'h5A5A_A5A5, $urandom, TO - 1, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    xfer(12'h010, 1'b0, $urandom, 32'h8765_4321, 0, 1'b0, 10);
  endtask

  task automatic test_reset_mid_access();
    @(negedge HCLK);
    req_valid = 1'b1; req_addr = 12'h024; req_write = 1'b1; req_wdata = 32'hFFFF_0001;
    @(negedge HCLK);
    req_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge HCLK);
    PREADY = 1'b0;
    @(negedge HCLK);
    PREADY = 1'b0;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      failures++; $display("FAIL mid_access_pre: psel=%b pen=%b want 1 1", PSEL, PENABLE);
    end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    check_reset_values("reset_mid_access");
    for (int i = 0; i < 20; i++) begin
      drive_junk();
      @(negedge HCLK);
      checks++;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
        failures++; $display("FAIL no_rsp_after_reset: rsp_valid=%b psel=%b want 0 0", rsp_valid, PSEL);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 5);
      xfer(AW'($urandom), 1'($urandom), $urandom, $urandom, w, 1'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    HRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    test_reset();
    test_write_basic();
    test_read_waits();
    test_read_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
